// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared defaults and word/address types for the register file
// with busy scoreboard. The typedefs describe the default geometry
// (32-bit words, 16 registers). Parameterised modules size their own vectors
// from their parameters.
package reg_file_pkg;
   localparam int DEF_DATA_W   = 32;
   localparam int DEF_NUM_REGS = 16;
   localparam int DEF_ADDR_W   = $clog2(DEF_NUM_REGS);
   localparam int WR_CNT_W     = 16;

   typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
   typedef logic [DEF_DATA_W-1:0] reg_word_t;
endpackage

// File: rtl/reg_file_rd_port.sv
// reg_file_rd_port: one combinational read port of the register file.
// It selects a word and its busy bit, with optional same-cycle write forwarding.
// Build option: REG_FILE_SB_BYPASS_EN enables forwarding of the in-flight write.
// Ports:
//   regs, busy     : storage and scoreboard from the top
//   ra             : read address
//   byp_vld        : a write commits on the coming edge (reset already excluded)
//   wa, wd         : write address / data
//   sb_set, sb_addr: qualified busy-set request for the coming edge
//   rd, bsy        : read data and busy flag
module reg_file_rd_port #(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 16,
   parameter int ADDR_W   = $clog2(NUM_REGS)
) (
   input  logic [NUM_REGS-1:0][DATA_W-1:0] regs,
   input  logic [NUM_REGS-1:0]             busy,
   input  logic [ADDR_W-1:0]               ra,
   input  logic                            byp_vld,
   input  logic [ADDR_W-1:0]               wa,
   input  logic [DATA_W-1:0]               wd,
   input  logic                            sb_set,
   input  logic [ADDR_W-1:0]               sb_addr,
   output logic [DATA_W-1:0]               rd,
   output logic                            bsy
);
`ifdef REG_FILE_SB_BYPASS_EN
   logic hit;
   assign hit = byp_vld && (wa == ra);
   assign rd  = hit ? wd : regs[ra];
   // A forwarded register has its producer retiring now. It shows busy only
   // when a new producer claims it on the same edge.
   assign bsy = hit ? (sb_set && (sb_addr == ra)) : busy[ra];
`else
   logic unused_byp;
   assign unused_byp = ^{byp_vld, wa, wd, sb_set, sb_addr};
   assign rd  = regs[ra];
   assign bsy = busy[ra];
`endif
endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: NUM_REGS x DATA_W register file. It has two combinational read
// ports, one clocked write port, a per-register busy scoreboard and a
// committed-write counter.
// Build option: REG_FILE_SB_BYPASS_EN forwards the in-flight write to reads.
// Ports:
//   Clk, Clr        : clock (rising), async active-low reset
//   LE, WA, WD      : writeback write enable / address / data; also clears busy[WA]
//   RA0/RA1         : read addresses; RD0/RD1 data; BUSY0/BUSY1 busy flags
//   SB_SET, SB_ADDR : issue marks SB_ADDR busy
//   WR_CNT          : committed write count, wraps silently
module reg_file_sb
   import reg_file_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int ADDR_W   = $clog2(NUM_REGS),
   parameter int ZERO_R0  = 1
) (
   input  logic                Clk,
   input  logic                Clr,
   input  logic                LE,
   input  logic [ADDR_W-1:0]   WA,
   input  logic [DATA_W-1:0]   WD,
   input  logic [ADDR_W-1:0]   RA0,
   input  logic [ADDR_W-1:0]   RA1,
   output logic [DATA_W-1:0]   RD0,
   output logic [DATA_W-1:0]   RD1,
   output logic                BUSY0,
   output logic                BUSY1,
   input  logic                SB_SET,
   input  logic [ADDR_W-1:0]   SB_ADDR,
   output logic [WR_CNT_W-1:0] WR_CNT
);
   logic [NUM_REGS-1:0][DATA_W-1:0] regs;
   logic [NUM_REGS-1:0]             busy, busy_nxt;
   logic [WR_CNT_W-1:0]             wr_cnt;
   logic                            wr_commit, set_ok, byp_vld;
   logic [1:0][ADDR_W-1:0]          ra;
   logic [1:0][DATA_W-1:0]          rd;
   logic [1:0]                      bsy;

   // R0 is never written and never marked busy. It therefore stays at its
   // reset value of 0, so the read path needs no special case.
   assign wr_commit = LE && !((ZERO_R0 != 0) && (WA == '0));
   assign set_ok    = SB_SET && !((ZERO_R0 != 0) && (SB_ADDR == '0));

   // Set is applied after clear so a new producer wins over a retiring one.
   always_comb begin
      busy_nxt = busy;
      if (wr_commit) busy_nxt[WA] = 1'b0;
      if (set_ok)    busy_nxt[SB_ADDR] = 1'b1;
   end

   always_ff @(posedge Clk or negedge Clr) begin
      if (!Clr) begin
         regs   <= '0;
         busy   <= '0;
         wr_cnt <= '0;
      end else begin
         busy <= busy_nxt;
         if (wr_commit) begin
            regs[WA] <= WD;
            wr_cnt   <= wr_cnt + 1'b1;
         end
      end
   end

   // Forwarding is gated by Clr so that reset forces every output to 0.
   assign byp_vld = Clr && wr_commit;
   assign ra      = {RA1, RA0};

   for (genvar p = 0; p < 2; p++) begin : g_rd
      reg_file_rd_port #(
         .DATA_W  (DATA_W),
         .NUM_REGS(NUM_REGS),
         .ADDR_W  (ADDR_W)
      ) u_rd (
         .regs   (regs),
         .busy   (busy),
         .ra     (ra[p]),
         .byp_vld(byp_vld),
         .wa     (WA),
         .wd     (WD),
         .sb_set (set_ok),
         .sb_addr(SB_ADDR),
         .rd     (rd[p]),
         .bsy    (bsy[p])
      );
   end

   assign RD0    = rd[0];
   assign RD1    = rd[1];
   assign BUSY0  = bsy[0];
   assign BUSY1  = bsy[1];
   assign WR_CNT = wr_cnt;
endmodule
